// File: rtl/alu_pipe_pkg.sv
// Shared types for the execute-stage ALU: opcode encodings, result flags and
// the iterative shifter state.
package alu_pipe_pkg;

    localparam int unsigned ALU_FLAGS_W = 4;

    typedef enum logic [3:0] {
        AluAdd  = 4'b0000,
        AluSll  = 4'b0001,
        AluSlt  = 4'b0010,
        AluSltu = 4'b0011,
        AluXor  = 4'b0100,
        AluSrl  = 4'b0101,
        AluOr   = 4'b0110,
        AluAnd  = 4'b0111,
        AluSub  = 4'b1000,
        AluSra  = 4'b1101
    } alu_op_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
    } alu_flags_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } shift_state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == AluSll) || (op == AluSrl) || (op == AluSra);
    endfunction

endpackage

// File: rtl/alu_pipe_shifter.sv
// Iterative shifter: moves at most SHIFT_STEP bits per cycle and presents the
// final step combinationally so stage 0 can hand it straight to stage 1.
module alu_pipe_shifter
    import alu_pipe_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     load,
    input  logic [3:0]               in_op,
    input  logic [XLEN-1:0]          in_a,
    input  logic [$clog2(XLEN)-1:0]  in_shamt,
    input  logic                     take,
    output logic                     busy,
    output logic [XLEN-1:0]          result
);

    localparam int unsigned    SHW  = $clog2(XLEN);
    localparam logic [SHW-1:0] STEP = SHW'(SHIFT_STEP);
    localparam logic [XLEN-1:0] ONES = '1;

    shift_state_e    state, state_d;
    logic [XLEN-1:0] acc, acc_d;
    logic [SHW-1:0]  rem, rem_d;
    logic            left, left_d;
    logic            fill, fill_d;

    logic [SHW-1:0]  amt;
    logic            last;
    logic [XLEN-1:0] stepped;

    // SRA refills from the sign captured at load, not from the partial value.
    always_comb begin
        last = (rem <= STEP);
        amt  = last ? rem : STEP;
        if (left) begin
            stepped = acc << amt;
        end else begin
            stepped = (acc >> amt) | (fill ? ~(ONES >> amt) : '0);
        end
    end

    assign busy   = (state == SHIFT) && !last;
    assign result = stepped;

    always_comb begin
        state_d = state;
        acc_d   = acc;
        rem_d   = rem;
        left_d  = left;
        fill_d  = fill;
        if (load) begin
            state_d = (in_shamt > STEP) ? SHIFT : IDLE;
            acc_d   = in_a;
            rem_d   = in_shamt;
            left_d  = (in_op == AluSll);
            fill_d  = (in_op == AluSra) && in_a[XLEN-1];
        end else if (state == SHIFT) begin
            if (!last) begin
                acc_d = stepped;
                rem_d = rem - STEP;
            end else if (take) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            acc   <= '0;
            rem   <= '0;
            left  <= 1'b0;
            fill  <= 1'b0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            rem   <= rem_d;
            left  <= left_d;
            fill  <= fill_d;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined RV32I/RV64I integer ALU: registered execute stage 0 followed by
// DEPTH result stages, valid/ready on both sides with full backpressure.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DEPTH      = 1,
    parameter int unsigned TAG_W      = 5,
    parameter int unsigned SHIFT_STEP = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [3:0]             i_op,
    input  logic [XLEN-1:0]        i_a,
    input  logic [XLEN-1:0]        i_b,
    input  logic [TAG_W-1:0]       i_tag,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [XLEN-1:0]        o_result,
    output logic [TAG_W-1:0]       o_tag,
    output logic [ALU_FLAGS_W-1:0] o_flags,
    output logic                   o_illegal
);

    localparam int unsigned SHW = $clog2(XLEN);

    typedef struct packed {
        logic [XLEN-1:0]  result;
        logic [TAG_W-1:0] tag;
        alu_flags_t       flags;
        logic             illegal;
    } stage_t;

    logic             vld0;
    logic [3:0]       op0;
    logic [XLEN-1:0]  a0, b0;
    logic [TAG_W-1:0] tag0;

    logic             s0_busy, s0_valid, accept;
    logic [XLEN-1:0]  shift_res;
    logic [XLEN:0]    add_full;
    logic [XLEN-1:0]  diff;
    stage_t           s0_data;

    logic             rdy   [1:DEPTH+1];
    logic             vld_q [1:DEPTH];
    stage_t           dat_q [1:DEPTH];

    // Stage 0 only offers its data once a multi-cycle shift reaches its last step.
    assign s0_valid = vld0 & ~s0_busy;
    assign o_ready  = ~s0_busy & (~vld0 | rdy[1]);
    assign accept   = i_valid & o_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld0 <= 1'b0;
            op0  <= '0;
            a0   <= '0;
            b0   <= '0;
            tag0 <= '0;
        end else if (o_ready) begin
            vld0 <= i_valid;
            if (i_valid) begin
                op0  <= i_op;
                a0   <= i_a;
                b0   <= i_b;
                tag0 <= i_tag;
            end
        end
    end

    assign add_full = {1'b0, a0} + {1'b0, b0};
    assign diff     = a0 - b0;

    always_comb begin
        s0_data         = '0;
        s0_data.tag     = tag0;
        case (op0)
            AluAdd: begin
                s0_data.result      = add_full[XLEN-1:0];
                s0_data.flags.carry = add_full[XLEN];
                s0_data.flags.ovf   = (a0[XLEN-1] == b0[XLEN-1]) &&
                                      (add_full[XLEN-1] != a0[XLEN-1]);
            end
            AluSub: begin
                s0_data.result      = diff;
                s0_data.flags.carry = (a0 < b0);
                s0_data.flags.ovf   = (a0[XLEN-1] != b0[XLEN-1]) &&
                                      (diff[XLEN-1] != a0[XLEN-1]);
            end
            AluSlt:  s0_data.result = {{(XLEN-1){1'b0}}, ($signed(a0) < $signed(b0))};
            AluSltu: s0_data.result = {{(XLEN-1){1'b0}}, (a0 < b0)};
            AluXor:  s0_data.result = a0 ^ b0;
            AluOr:   s0_data.result = a0 | b0;
            AluAnd:  s0_data.result = a0 & b0;
            AluSll, AluSrl, AluSra: s0_data.result = shift_res;
            default: s0_data.illegal = 1'b1;
        endcase
        if (!s0_data.illegal) begin
            s0_data.flags.zero = ~|s0_data.result;
            s0_data.flags.neg  = s0_data.result[XLEN-1];
        end
    end

    generate
        if (SHIFT_STEP < XLEN) begin : g_iter_shift
            alu_pipe_shifter #(
                .XLEN       (XLEN),
                .SHIFT_STEP (SHIFT_STEP)
            ) u_shifter (
                .clk      (clk),
                .rstn     (rstn),
                .load     (accept && is_shift_op(i_op)),
                .in_op    (i_op),
                .in_a     (i_a),
                .in_shamt (i_b[SHW-1:0]),
                .take     (s0_valid && rdy[1]),
                .busy     (s0_busy),
                .result   (shift_res)
            );
        end else begin : g_comb_shift
            logic [SHW-1:0] shamt;
            assign shamt   = b0[SHW-1:0];
            assign s0_busy = 1'b0;
            always_comb begin
                case (op0)
                    AluSll:  shift_res = a0 << shamt;
                    AluSra:  shift_res = $unsigned($signed(a0) >>> shamt);
                    default: shift_res = a0 >> shamt;
                endcase
            end
        end
    endgenerate

    assign rdy[DEPTH+1] = i_ready;

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        logic   src_vld, vld_r;
        stage_t src_dat, dat_r;

        if (k == 1) begin : g_first
            assign src_vld = s0_valid;
            assign src_dat = s0_data;
        end else begin : g_next
            assign src_vld = vld_q[k-1];
            assign src_dat = dat_q[k-1];
        end

        assign rdy[k]   = ~vld_r | rdy[k+1];
        assign vld_q[k] = vld_r;
        assign dat_q[k] = dat_r;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                vld_r <= 1'b0;
                dat_r <= '0;
            end else if (rdy[k]) begin
                vld_r <= src_vld;
                if (src_vld) begin
                    dat_r <= src_dat;
                end
            end
        end
    end

    assign o_valid   = vld_q[DEPTH];
    assign o_result  = dat_q[DEPTH].result;
    assign o_tag     = dat_q[DEPTH].tag;
    assign o_flags   = dat_q[DEPTH].flags;
    assign o_illegal = dat_q[DEPTH].illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (XLEN=32, DEPTH=1, SHIFT_STEP=8) with
// hand-computed expectations checked by immediate assertions.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    logic        clk;
    logic        rstn;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_op;
    logic [31:0] i_a, i_b;
    logic [4:0]  i_tag;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic [4:0]  o_tag;
    logic [3:0]  o_flags;
    logic        o_illegal;

    int n_run  = 0;
    int n_fail = 0;

    alu_pipe #(
        .XLEN       (32),
        .DEPTH      (1),
        .TAG_W      (5),
        .SHIFT_STEP (8)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_op      (i_op),
        .i_a       (i_a),
        .i_b       (i_b),
        .i_tag     (i_tag),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_result  (o_result),
        .o_tag     (o_tag),
        .o_flags   (o_flags),
        .o_illegal (o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One op through an otherwise idle pipe; flags are {zero,neg,carry,ovf}.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp_res,
                          input logic [3:0] exp_flags, input logic exp_ill, input int exp_lat,
                          input int exp_lows);
        int lat;
        int lows;
        i_valid = 1'b1;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        i_tag   = tag;
        #1;
        check({name, "_ready"}, 32'(o_ready), 32'd1);
        tick();
        i_valid = 1'b0;
        lat  = 1;
        lows = 0;
        while (!o_valid && lat < 20) begin
            if (!o_ready) lows++;
            tick();
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_ready_low"}, 32'(lows), 32'(exp_lows));
        check({name, "_result"}, o_result, exp_res);
        check({name, "_flags"}, 32'(o_flags), 32'(exp_flags));
        check({name, "_tag"}, 32'(o_tag), 32'(tag));
        check({name, "_illegal"}, 32'(o_illegal), 32'(exp_ill));
        tick();
    endtask

    initial begin
        int sent;
        int rcvd;

        rstn    = 1'b0;
        i_valid = 1'b0;
        i_op    = '0;
        i_a     = '0;
        i_b     = '0;
        i_tag   = '0;
        i_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_result", o_result, 32'd0);
        check("rst_tag", 32'(o_tag), 32'd0);
        check("rst_flags", 32'(o_flags), 32'd0);
        check("rst_illegal", 32'(o_illegal), 32'd0);
        rstn = 1'b1;
        #1;
        check("rst_ready", 32'(o_ready), 32'd1);
        tick();

        run_op("add_ovf",  AluAdd,  32'h7FFF_FFFF, 32'h1,          5'd3,  32'h8000_0000, 4'b0101, 1'b0, 2, 0);
        run_op("sub_zero", AluSub,  32'd5,         32'd5,          5'd4,  32'h0,         4'b1000, 1'b0, 2, 0);
        run_op("sub_brw",  AluSub,  32'd0,         32'd1,          5'd5,  32'hFFFF_FFFF, 4'b0110, 1'b0, 2, 0);
        run_op("add_cy",   AluAdd,  32'hFFFF_FFFF, 32'h1,          5'd6,  32'h0,         4'b1010, 1'b0, 2, 0);
        run_op("sub_ovf",  AluSub,  32'h8000_0000, 32'h1,          5'd7,  32'h7FFF_FFFF, 4'b0001, 1'b0, 2, 0);
        run_op("slt",      AluSlt,  32'hFFFF_FFFF, 32'h1,          5'd8,  32'h1,         4'b0000, 1'b0, 2, 0);
        run_op("sltu",     AluSltu, 32'hFFFF_FFFF, 32'h1,          5'd9,  32'h0,         4'b1000, 1'b0, 2, 0);
        run_op("xor",      AluXor,  32'hF0F0_F0F0, 32'hFF00_FF00,  5'd10, 32'h0FF0_0FF0, 4'b0000, 1'b0, 2, 0);
        run_op("or",       AluOr,   32'hF0F0_F0F0, 32'hFF00_FF00,  5'd11, 32'hFFF0_FFF0, 4'b0100, 1'b0, 2, 0);
        run_op("and",      AluAnd,  32'hF0F0_F0F0, 32'hFF00_FF00,  5'd12, 32'hF000_F000, 4'b0100, 1'b0, 2, 0);
        run_op("sra20",    AluSra,  32'h8000_0000, 32'd20,         5'd13, 32'hFFFF_F800, 4'b0100, 1'b0, 4, 2);
        run_op("sll0",     AluSll,  32'h1,         32'd0,          5'd14, 32'h1,         4'b0000, 1'b0, 2, 0);
        run_op("sll31",    AluSll,  32'h1,         32'h3F,         5'd15, 32'h8000_0000, 4'b0100, 1'b0, 5, 3);
        run_op("srl8",     AluSrl,  32'h8000_0000, 32'd8,          5'd16, 32'h0080_0000, 4'b0000, 1'b0, 2, 0);
        run_op("srl9",     AluSrl,  32'hF000_0000, 32'd9,          5'd17, 32'h0078_0000, 4'b0000, 1'b0, 3, 1);
        run_op("sra31",    AluSra,  32'h8000_0000, 32'd31,         5'd18, 32'hFFFF_FFFF, 4'b0100, 1'b0, 5, 3);
        run_op("illegal",  4'b1111, 32'h1234,      32'h5678,       5'h1A, 32'h0,         4'b0000, 1'b1, 2, 0);

        // Ten back-to-back ADDs against a consumer stalled for six cycles.
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 100 && (sent < 10 || rcvd < 10); cyc++) begin
            i_ready = (cyc >= 6);
            i_valid = (sent < 10);
            i_op    = AluAdd;
            i_a     = 32'(sent);
            i_b     = 32'd100;
            i_tag   = 5'(sent);
            #1;
            if (cyc >= 2 && cyc < 6) begin
                check("stall_ready", 32'(o_ready), 32'd0);
                check("stall_valid", 32'(o_valid), 32'd1);
                check("stall_result", o_result, 32'd100);
                check("stall_tag", 32'(o_tag), 32'd0);
            end
            if (cyc == 5) check("stall_accepted", 32'(sent), 32'd2);
            if (o_valid && i_ready) begin
                check("stream_tag", 32'(o_tag), 32'(rcvd));
                check("stream_result", o_result, 32'(rcvd + 100));
                rcvd++;
            end
            if (i_valid && o_ready) sent++;
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        check("stream_sent", 32'(sent), 32'd10);
        check("stream_rcvd", 32'(rcvd), 32'd10);
        tick();
        check("stream_drained", 32'(o_valid), 32'd0);

        // Reset while an ADD waits at the output and an SLL is mid-shift.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_op    = AluAdd;
        i_a     = 32'd1;
        i_b     = 32'd1;
        i_tag   = 5'd1;
        tick();
        i_op    = AluSll;
        i_b     = 32'd31;
        i_tag   = 5'd2;
        #1;
        check("mid_ready", 32'(o_ready), 32'd1);
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        check("mid_valid", 32'(o_valid), 32'd1);
        check("mid_tag", 32'(o_tag), 32'd1);
        check("mid_busy", 32'(o_ready), 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_result", o_result, 32'd0);
        check("arst_tag", 32'(o_tag), 32'd0);
        check("arst_ready", 32'(o_ready), 32'd1);
        tick();
        rstn    = 1'b1;
        i_ready = 1'b1;
        tick();
        run_op("post_rst", AluAdd, 32'd2, 32'd3, 5'd7, 32'd5, 4'b0000, 1'b0, 2, 0);
        check("post_rst_empty", 32'(o_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
